// File: rtl/fetch_pkg.sv
// Shared types and default vectors for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: exception > branch > jump > hold > sequential.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic [PC_WIDTH-1:0]  i_pc_plus4,
  input  logic                 i_hold,
  input  logic                 i_exc_req,
  input  logic                 i_br_taken,
  input  logic [PC_WIDTH-1:0]  i_br_base,
  input  logic [IMM_WIDTH-1:0] i_br_imm,
  input  logic                 i_jmp,
  input  logic [PC_WIDTH-1:0]  i_jmp_target,
  output logic [PC_WIDTH-1:0]  o_next_pc,
  output logic                 o_redirect
);

  // Offset is extended to whichever is wider so narrow PCs still see the correct low bits.
  localparam int unsigned EXT_W = (PC_WIDTH > IMM_WIDTH + 2) ? PC_WIDTH : IMM_WIDTH + 2;

  logic signed [IMM_WIDTH+1:0] w_off;
  logic signed [EXT_W-1:0]     w_off_ext;
  logic [PC_WIDTH-1:0]         w_br_target;
  logic [PC_WIDTH-1:0]         w_jmp_target;

  assign w_off        = {i_br_imm, 2'b00};
  assign w_off_ext    = EXT_W'(w_off);
  assign w_br_target  = i_br_base + w_off_ext[PC_WIDTH-1:0];
  assign w_jmp_target = {i_jmp_target[PC_WIDTH-1:2], 2'b00};
  assign o_redirect   = i_exc_req | i_br_taken | i_jmp;

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_exc_req)       o_next_pc = EXC_VECTOR[PC_WIDTH-1:0];
    else if (i_br_taken) o_next_pc = w_br_target;
    else if (i_jmp)      o_next_pc = w_jmp_target;
    else if (i_hold)     o_next_pc = i_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned IMM_WIDTH    = 16,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [PC_WIDTH-1:0]  br_base,
  input  logic [IMM_WIDTH-1:0] br_imm,
  input  logic                 jmp,
  input  logic [PC_WIDTH-1:0]  jmp_target,
  input  logic                 exc_req,
  input  logic                 halt_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          if_id_instr,
  output logic [PC_WIDTH-1:0]  if_id_pcplus4,
  output logic                 if_id_valid,
  output logic                 halted
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pcplus4;
  logic                r_valid;
  logic                w_redirect;
  logic                w_hold;
  logic                w_capture;

  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  // BOOT holds the PC so the reset-vector instruction is fetched on the first RUN cycle.
  assign w_hold     = stall | (r_state != RUN);
  assign w_capture  = (r_state == RUN) & ~halt_req;

  next_pc_sel #(
    .PC_WIDTH  (PC_WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_sel (
    .i_pc        (r_pc),
    .i_pc_plus4  (w_pc_plus4),
    .i_hold      (w_hold),
    .i_exc_req   (exc_req),
    .i_br_taken  (br_taken),
    .i_br_base   (br_base),
    .i_br_imm    (br_imm),
    .i_jmp       (jmp),
    .i_jmp_target(jmp_target),
    .o_next_pc   (w_next_pc),
    .o_redirect  (w_redirect)
  );

  // A stalled halt request is deferred so the held IF/ID contents stay intact.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (!w_redirect && !stall && halt_req) w_state_nxt = HALT;
      HALT:    if (w_redirect) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VECTOR[PC_WIDTH-1:0];
      r_instr   <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_next_pc;
      if (w_redirect) begin
        r_valid <= 1'b0;
      end else if (!stall) begin
        if (w_capture) begin
          r_instr   <= imem_rdata;
          r_pcplus4 <= w_pc_plus4;
          r_valid   <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_addr     = r_pc;
  assign if_id_instr   = r_instr;
  assign if_id_pcplus4 = r_pcplus4;
  assign if_id_valid   = r_valid;
  assign halted        = (r_state == HALT);

endmodule
